// File: rtl/seq_divider32b.sv
// Multi-cycle 32-bit RV32M divider (DIV/DIVU/REM/REMU) using restoring shift-and-subtract.
// Latency: 34 cycles from an accepted start to the done pulse; 1 cycle for divide-by-zero/overflow.
// No backpressure: start is ignored while busy, and done is a one-cycle pulse that must be captured.
module seq_divider32b (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        op_rem;      // latched op[1]: 1 = remainder result
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  cnt;
  logic [31:0] babs;
  logic [31:0] r;
  logic [31:0] q;

  logic        is_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div0;
  logic        ovf;
  logic        special;
  logic [31:0] special_res;
  logic [32:0] t;
  logic [32:0] d;
  logic [31:0] fix_res;

  // Operand conditioning, special-case detection, one restoring step and final sign fix-up
  always_comb begin
    is_signed   = ~op[0];
    a_abs       = (is_signed && a[31]) ? (32'd0 - a) : a;
    b_abs       = (is_signed && b[31]) ? (32'd0 - b) : b;
    div0        = (b == 32'd0);
    ovf         = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special     = div0 || ovf;
    special_res = 32'd0;
    if (div0) begin
      special_res = op[1] ? a : 32'hFFFF_FFFF;
    end else if (ovf) begin
      special_res = op[1] ? 32'd0 : 32'h8000_0000;
    end
    t = {r, q[31]};
    d = t - {1'b0, babs};
    if (op_rem) begin
      fix_res = neg_r ? (32'd0 - r) : r;
    end else begin
      fix_res = neg_q ? (32'd0 - q) : q;
    end
  end

  // Next-state logic: special cases complete straight from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !special) begin
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (cnt == 5'd0) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 5'd0;
      r      <= 32'd0;
      q      <= 32'd0;
      babs   <= 32'd0;
      op_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_rem <= op[1];
            neg_q  <= is_signed && (a[31] ^ b[31]);
            neg_r  <= is_signed && a[31];
            babs   <= b_abs;
            cnt    <= 5'd31;
            r      <= 32'd0;
            q      <= a_abs;
          end
        end
        ITER: begin
          if (!d[32]) begin
            r <= d[31:0];
            q <= {q[30:0], 1'b1};
          end else begin
            r <= t[31:0];
            q <= {q[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result register and one-cycle done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start && special) begin
        done   <= 1'b1;
        result <= special_res;
      end else if (state == FIX) begin
        done   <= 1'b1;
        result <= fix_res;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
